// File: rtl/wb_backdoor_mem.sv
// +----------------------------------------------------------------------------+
// | wb_backdoor_mem : shared word memory with a zero-wait backdoor port and a  |
// | Wishbone B3 classic slave port.                          Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_backdoor_mem #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  input  logic                bd_write,
  input  logic                bd_read,
  input  logic [ADDR_W-1:0]   bd_addr,
  input  logic [DATA_W-1:0]   bd_wdata,
  output logic [DATA_W-1:0]   bd_rdata,
  output logic                bd_rvalid,
  output logic [15:0]         bd_wr_count,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NBYTES = DATA_W / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [DATA_W-1:0]     r_mem [0:DEPTH-1];
  logic [0:0]            r_state;
  logic [0:0]            w_next;
  logic                  r_run;
  logic                  r_err;
  logic [DATA_W-1:0]     r_dat_o;
  logic [DATA_W-1:0]     r_bd_rdata;
  logic                  r_bd_rvalid;
  logic [15:0]           r_bd_cnt;

  logic                  w_bd_in;
  logic [DEPTH_LOG2-1:0] w_bd_idx;
  logic                  w_bd_we;
  logic [ADDR_W-1:0]     w_wb_off;
  logic                  w_wb_in;
  logic [DEPTH_LOG2-1:0] w_wb_idx;
  logic                  w_req;
  logic                  w_collide;
  logic                  w_accept;

  assign w_bd_in   = (bd_addr >> DEPTH_LOG2) == '0;
  assign w_bd_idx  = bd_addr[DEPTH_LOG2-1:0];
  assign w_bd_we   = r_run && bd_write && w_bd_in;

  assign w_wb_off  = wb_adr_i - BASE_ADDR;
  assign w_wb_in   = (wb_adr_i >= BASE_ADDR) && ((w_wb_off >> (DEPTH_LOG2 + 2)) == '0);
  assign w_wb_idx  = w_wb_off[DEPTH_LOG2+1:2];

  // A backdoor write to the same word wins; the bus transfer waits a cycle.
  assign w_req     = wb_cyc_i && wb_stb_i;
  assign w_collide = w_bd_we && w_wb_in && (w_bd_idx == w_wb_idx);
  assign w_accept  = (r_state == S_IDLE) && w_req && !w_collide && r_run;

  // r_run gates memory writes so nothing is stored while reset is asserted.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    if (r_state == S_ACK) begin
      wb_ack_o = !r_err;
      wb_err_o = r_err;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else if (w_accept) begin
      r_err <= !w_wb_in;
      if (w_wb_in && !wb_we_i) begin
        r_dat_o <= r_mem[w_wb_idx];
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_bd_we) begin
      r_mem[w_bd_idx] <= bd_wdata;
    end
    if (w_accept && w_wb_in && wb_we_i) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wb_sel_i[k]) begin
          r_mem[w_wb_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
        end
      end
    end
  end

  // Nonblocking read of r_mem gives read-before-write on a same-address write.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_bd_rdata  <= '0;
      r_bd_rvalid <= 1'b0;
      r_bd_cnt    <= '0;
    end else begin
      r_bd_rvalid <= bd_read;
      if (bd_read) begin
        r_bd_rdata <= w_bd_in ? r_mem[w_bd_idx] : '0;
      end
      if (w_bd_we && (r_bd_cnt != 16'hFFFF)) begin
        r_bd_cnt <= r_bd_cnt + 16'd1;
      end
    end
  end

  assign bd_rdata    = r_bd_rdata;
  assign bd_rvalid   = r_bd_rvalid;
  assign bd_wr_count = r_bd_cnt;
  assign wb_dat_o    = r_dat_o;

endmodule

`default_nettype wire

// File: tb/tb_wb_backdoor_mem.sv
// +----------------------------------------------------------------------------+
// | tb_wb_backdoor_mem : directed self-checking bench for wb_backdoor_mem.     |
// |                                                          Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_backdoor_mem;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        bd_write = 1'b0;
  logic        bd_read = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_wdata = '0;
  logic [31:0] bd_rdata;
  logic        bd_rvalid;
  logic [15:0] bd_wr_count;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  lat;
  logic        ack;
  logic        err;
  logic [31:0] rdat;

  wb_backdoor_mem #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .DEPTH_LOG2(10),
    .BASE_ADDR (BASE)
  ) u_dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .bd_write   (bd_write),
    .bd_read    (bd_read),
    .bd_addr    (bd_addr),
    .bd_wdata   (bd_wdata),
    .bd_rdata   (bd_rdata),
    .bd_rvalid  (bd_rvalid),
    .bd_wr_count(bd_wr_count),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic bd_wr(input logic [31:0] a, input logic [31:0] d);
    bd_write = 1'b1;
    bd_addr  = a;
    bd_wdata = d;
    tick();
    bd_write = 1'b0;
  endtask

  task automatic bd_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bd_read = 1'b1;
    bd_addr = a;
    tick();
    bd_read = 1'b0;
    check(tag, {31'd0, bd_rvalid, bd_rdata}, {31'd0, 1'b1, exp});
  endtask

  // Holds the strobe until ack/err (bounded), optionally with a colliding backdoor write.
  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [3:0] sel,
                         input logic [31:0] d, input logic bd_hit, input logic [31:0] bd_d,
                         output logic [7:0] o_lat, output logic o_ack, output logic o_err,
                         output logic [31:0] o_dat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = a;
    wb_sel_i = sel;
    wb_dat_i = d;
    if (bd_hit) begin
      bd_write = 1'b1;
      bd_addr  = (a - BASE) >> 2;
      bd_wdata = bd_d;
    end
    o_lat = 8'd0;
    o_ack = 1'b0;
    o_err = 1'b0;
    while (o_lat < 8'd8 && !(o_ack || o_err)) begin
      tick();
      bd_write = 1'b0;
      o_lat++;
      o_ack = wb_ack_o;
      o_err = wb_err_o;
    end
    o_dat    = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
    check("single_cycle_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {bd_wr_count, bd_rvalid, wb_ack_o, wb_err_o, 13'd0, wb_dat_o},
          64'd0);
    check("reset_bd_rdata", {32'd0, bd_rdata}, 64'd0);
    wb_rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      bd_write = 1'b1;
      bd_addr  = 32'd5 + i;
      bd_wdata = 32'hA0 + i;
      tick();
    end
    bd_write = 1'b0;
    check("burst_count", {48'd0, bd_wr_count}, 64'd10);

    for (int i = 0; i < 10; i++) begin
      bd_rd($sformatf("bd_read_%0d", 5 + i), 32'd5 + i, 32'hA0 + i);
    end
    tick();
    check("rvalid_drops", {63'd0, bd_rvalid}, 64'd0);

    wb_xfer(1'b0, BASE + 32'h14, 4'hF, 32'h0, 1'b0, 32'h0, lat, ack, err, rdat);
    check("wb_read_0x14", {22'd0, lat, ack, err, rdat}, {22'd0, 8'd1, 1'b1, 1'b0, 32'hA0});
    wb_xfer(1'b0, BASE + 32'h38, 4'hF, 32'h0, 1'b0, 32'h0, lat, ack, err, rdat);
    check("wb_read_0x38", {22'd0, lat, ack, err, rdat}, {22'd0, 8'd1, 1'b1, 1'b0, 32'hA9});

    wb_xfer(1'b1, BASE + 32'h14, 4'b0101, 32'h1122_3344, 1'b0, 32'h0, lat, ack, err, rdat);
    check("wb_write_sel_ack", {54'd0, lat, ack, err}, {54'd0, 8'd1, 1'b1, 1'b0});
    bd_rd("byte_merge", 32'd5, 32'h0022_0044);

    wb_xfer(1'b1, BASE + 32'h1C, 4'hF, 32'hBEEF, 1'b1, 32'hDEAD, lat, ack, err, rdat);
    check("collide_wr_lat", {54'd0, lat, ack, err}, {54'd0, 8'd2, 1'b1, 1'b0});
    bd_rd("collide_wr_data", 32'd7, 32'hBEEF);
    wb_xfer(1'b0, BASE + 32'h1C, 4'hF, 32'h0, 1'b1, 32'hDEAD, lat, ack, err, rdat);
    check("collide_rd", {22'd0, lat, ack, err, rdat}, {22'd0, 8'd2, 1'b1, 1'b0, 32'hDEAD});
    check("collide_count", {48'd0, bd_wr_count}, 64'd12);

    bd_wr(32'd0, 32'h1234_5678);
    bd_wr(32'd1024, 32'h0000_0077);
    check("oor_bd_wr_count", {48'd0, bd_wr_count}, 64'd13);
    wb_xfer(1'b1, BASE + 32'd4096, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, lat, ack, err, rdat);
    check("oow_write_err", {22'd0, lat, ack, err, rdat}, {22'd0, 8'd1, 1'b0, 1'b1, 32'hDEAD});
    wb_xfer(1'b0, BASE - 32'd4, 4'hF, 32'h0, 1'b0, 32'h0, lat, ack, err, rdat);
    check("below_base_err", {54'd0, lat, ack, err}, {54'd0, 8'd1, 1'b0, 1'b1});
    bd_rd("no_wrap_word0", 32'd0, 32'h1234_5678);
    bd_rd("oor_bd_read", 32'd1024, 32'h0);

    for (int i = 0; i < 10; i++) bd_wr(32'd100 + i, 32'h1000 + i);
    check("preload_count", {48'd0, bd_wr_count}, 64'd23);
    for (int i = 0; i < 10; i++) begin
      bd_write = 1'b1;
      bd_addr  = 32'd100 + i;
      bd_wdata = 32'h2000 + i;
      if (i == 4) begin
        #2 wb_rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {bd_wr_count, bd_rvalid, wb_ack_o, wb_err_o, 13'd0, wb_dat_o}, 64'd0);
      end
      tick();
    end
    bd_write = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    repeat (2) tick();
    check("count_after_reset", {48'd0, bd_wr_count}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      bd_rd($sformatf("reset_burst_%0d", 100 + i), 32'd100 + i,
            (i < 4) ? (32'h2000 + i) : (32'h1000 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
